// File: rtl/imem_fetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction memory and decode.
//
// Handshake semantics (decode side):
//   out_valid is high whenever the fetch unit presents an instruction.
//   A transfer happens on a rising clk edge where out_valid and out_ready are
//   both high and redirect_valid is low. out_valid never depends on out_ready.
//   A head shown during a redirect cycle is killed, not transferred.
//   The instruction memory side has no handshake: imem_dout must be the word
//   at imem_addr within the same cycle.
//
// Modports:
//   master : the fetch unit (drives imem_addr and the out_* / status signals)
//   slave  : memory + decode + redirect source (the environment)
interface imem_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        misalign_err;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr,
    input  imem_dout,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    output out_inst,
    output out_pc,
    input  out_ready,
    output misalign_err,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_dout,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    input  out_inst,
    input  out_pc,
    output out_ready,
    input  misalign_err,
    input  fetch_count
  );
endinterface

// File: rtl/imem_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads a combinational
// instruction memory, and queues {pc, instruction} pairs in a small circular
// buffer that feeds decode through a valid/ready handshake.
//
// Ports:
//   clk    : single clock, all state changes on the rising edge
//   rst_n  : synchronous active-low reset
//   bus    : imem_fetch_unit_if.master
//            imem_addr/imem_dout      - memory address out, word back same cycle
//            redirect_valid/_pc       - restart fetch elsewhere, flushes buffer
//            out_valid/_inst/_pc/ready - decode handshake from the buffer head
//            misalign_err             - sticky, set by a misaligned redirect
//            fetch_count              - words pushed since reset (wraps)
module imem_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_fetch_unit_if.master bus
);

  localparam int            PW      = $clog2(BUF_DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(BUF_DEPTH);

  logic [31:0]   fpc;
  logic [31:0]   buf_pc   [BUF_DEPTH];
  logic [31:0]   buf_inst [BUF_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic [PW:0]   count_nxt;
  logic          misalign;
  logic [31:0]   fcount;

  logic out_valid_int;
  logic pop;
  logic push;

  assign out_valid_int = (count != '0);

  // A redirect kills the head shown this cycle, so it is never consumed.
  assign pop  = out_valid_int & bus.out_ready & ~bus.redirect_valid;
  // A full buffer still accepts a word when the head leaves the same cycle.
  assign push = ~bus.redirect_valid & ((count < DEPTH_C) | pop);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + (PW+1)'(1);
      2'b01:   count_nxt = count - (PW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpc      <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      misalign <= 1'b0;
      fcount   <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc[i]   <= '0;
        buf_inst[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      // Flush: pointers restart together so the buffer reads as empty.
      fpc   <= {bus.redirect_pc[31:2], 2'b00};
      head  <= '0;
      tail  <= '0;
      count <= '0;
      if (bus.redirect_pc[1:0] != 2'b00) begin
        misalign <= 1'b1;
      end
    end else begin
      if (push) begin
        buf_pc[tail]   <= fpc;
        buf_inst[tail] <= bus.imem_dout;
        tail           <= tail + PW'(1);
        fpc            <= fpc + 32'd4;
        fcount         <= fcount + 32'd1;
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count <= count_nxt;
    end
  end

  assign bus.imem_addr    = fpc;
  assign bus.out_valid    = out_valid_int;
  assign bus.out_pc       = buf_pc[head];
  assign bus.out_inst     = buf_inst[head];
  assign bus.misalign_err = misalign;
  assign bus.fetch_count  = fcount;

endmodule

// File: tb/tb_imem_fetch_unit.sv
module tb_imem_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'd0;
  localparam logic [31:0] MAGIC    = 32'hA5A50000;

  logic clk;
  logic rst_n;

  imem_fetch_unit_if bus();

  imem_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Combinational instruction memory model.
  assign bus.imem_dout = bus.imem_addr ^ MAGIC;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int pops   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] next_push_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic start_stream(input logic [31:0] pc);
    exp_q.delete();
    next_push_pc = pc;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(next_push_pc);
      next_push_pc = next_push_pc + 32'd4;
    end
  endtask

  task automatic sb_cycle(input logic r, input logic rv, input logic rdy);
    logic [31:0] e;
    if (r && !rv && rdy && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got pc %h expected no transfer", bus.out_pc);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", bus.out_pc, e);
        check("sb_inst", bus.out_inst, e ^ MAGIC);
        pops++;
        if (exp_q.size() < 4) begin
          for (int i = 0; i < 4; i++) begin
            exp_q.push_back(next_push_pc);
            next_push_pc = next_push_pc + 32'd4;
          end
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called at the falling edge: drive inputs, settle, then sample outputs
  // for this cycle before the rising edge consumes the inputs.
  task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    rst_n              = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    #1;
  endtask

  task automatic after_cycle(input logic r, input logic rv, input logic [31:0] rpc);
    if (!r) start_stream(RESET_PC);
    else if (rv) start_stream({rpc[31:2], 2'b00});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        r;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic        zc;    // reset-state row: out_pc/out_inst must read zero
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        emis;
    logic [31:0] efc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic ev, input logic zc, input logic [31:0] epc,
                     input logic [31:0] eaddr, input logic emis, input logic [31:0] efc);
    vec_t v;
    v.r = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.zc = zc; v.epc = epc; v.eaddr = eaddr; v.emis = emis; v.efc = efc;
    tbl.push_back(v);
  endtask

  logic exp_mis;
  logic rv_r;
  logic rdy_r;
  logic [31:0] rpc_r;

  initial begin
    // Reset release with out_ready=1: one instruction per cycle.
    add(1, 0, 0, 1,  0, 1, 32'h0,  32'h0,  0, 0);
    add(1, 0, 0, 1,  1, 0, 32'h0,  32'h4,  0, 1);
    add(1, 0, 0, 1,  1, 0, 32'h4,  32'h8,  0, 2);
    add(1, 0, 0, 1,  1, 0, 32'h8,  32'hC,  0, 3);
    add(1, 0, 0, 1,  1, 0, 32'hC,  32'h10, 0, 4);
    // Reset again, then hold out_ready=0 for 6 cycles: buffer fills, fpc stalls.
    add(0, 0, 0, 0,  1, 0, 32'h10, 32'h14, 0, 5);
    add(1, 0, 0, 0,  0, 1, 32'h0,  32'h0,  0, 0);
    add(1, 0, 0, 0,  1, 0, 32'h0,  32'h4,  0, 1);
    add(1, 0, 0, 0,  1, 0, 32'h0,  32'h8,  0, 2);
    add(1, 0, 0, 0,  1, 0, 32'h0,  32'h8,  0, 2);
    add(1, 0, 0, 0,  1, 0, 32'h0,  32'h8,  0, 2);
    add(1, 0, 0, 0,  1, 0, 32'h0,  32'h8,  0, 2);
    // Drain while full: push and pop together.
    add(1, 0, 0, 1,  1, 0, 32'h0,  32'h8,  0, 2);
    add(1, 0, 0, 1,  1, 0, 32'h4,  32'hC,  0, 3);
    add(1, 0, 0, 0,  1, 0, 32'h8,  32'h10, 0, 4);
    // Redirect to 0x40 with two entries buffered; head not consumed.
    add(1, 1, 32'h40, 1, 1, 0, 32'h8,  32'h10, 0, 4);
    add(1, 0, 0, 1,  0, 0, 32'h0,  32'h40, 0, 4);
    add(1, 0, 0, 1,  1, 0, 32'h40, 32'h44, 0, 5);
    add(1, 0, 0, 1,  1, 0, 32'h44, 32'h48, 0, 6);
    // Misaligned redirect: sticky error, address aligned.
    add(1, 1, 32'h43, 1, 1, 0, 32'h48, 32'h4C, 0, 7);
    add(1, 0, 0, 1,  0, 0, 32'h0,  32'h40, 1, 7);
    // Redirect near the top of the address space: fpc wraps.
    add(1, 1, 32'hFFFFFFF8, 1, 1, 0, 32'h40, 32'h44, 1, 8);
    add(1, 0, 0, 1,  0, 0, 32'h0,        32'hFFFFFFF8, 1, 8);
    add(1, 0, 0, 1,  1, 0, 32'hFFFFFFF8, 32'hFFFFFFFC, 1, 9);
    add(1, 0, 0, 1,  1, 0, 32'hFFFFFFFC, 32'h0,        1, 10);
    add(1, 0, 0, 1,  1, 0, 32'h0,        32'h4,        1, 11);
    add(1, 0, 0, 0,  1, 0, 32'h4,        32'h8,        1, 12);
    // Reset while full with a misaligned redirect asserted: reset wins.
    add(0, 1, 32'h81, 0, 1, 0, 32'h4, 32'hC, 1, 13);
    add(1, 0, 0, 0,  0, 1, 32'h0,  32'h0,  0, 0);
    add(1, 0, 0, 1,  1, 0, 32'h0,  32'h4,  0, 1);
    add(1, 0, 0, 1,  1, 0, 32'h4,  32'h8,  0, 2);

    // Preamble reset.
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    start_stream(RESET_PC);
    repeat (2) @(posedge clk);

    // Table-driven phase.
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].r, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      check($sformatf("v%0d_valid", i), {31'd0, bus.out_valid}, {31'd0, tbl[i].ev});
      check($sformatf("v%0d_addr", i),  bus.imem_addr, tbl[i].eaddr);
      check($sformatf("v%0d_mis", i),   {31'd0, bus.misalign_err}, {31'd0, tbl[i].emis});
      check($sformatf("v%0d_fcnt", i),  bus.fetch_count, tbl[i].efc);
      if (tbl[i].ev || tbl[i].zc) begin
        check($sformatf("v%0d_pc", i), bus.out_pc, tbl[i].epc);
      end
      if (tbl[i].zc) begin
        check($sformatf("v%0d_inst0", i), bus.out_inst, 32'h0);
      end
      sb_cycle(tbl[i].r, tbl[i].rv, tbl[i].rdy);
      after_cycle(tbl[i].r, tbl[i].rv, tbl[i].rpc);
    end

    // Random phase: random back-pressure and occasional redirects; ordering
    // and data go through the scoreboard, the sticky flag through exp_mis.
    pops    = 0;
    exp_mis = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rdy_r = ($urandom_range(0, 3) != 0);
      rv_r  = ($urandom_range(0, 15) == 0);
      rpc_r = $urandom;
      drive(1'b1, rv_r, rpc_r, rdy_r);
      check("rnd_mis", {31'd0, bus.misalign_err}, {31'd0, exp_mis});
      check("rnd_align", {30'd0, bus.imem_addr[1:0]}, 32'd0);
      sb_cycle(1'b1, rv_r, rdy_r);
      after_cycle(1'b1, rv_r, rpc_r);
      if (rv_r && rpc_r[1:0] != 2'b00) exp_mis = 1'b1;
    end
    check("rnd_progress", {31'd0, (pops > 100)}, 32'd1);

    @(negedge clk);
    bus.redirect_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
